// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter granting one register-manager requester at a time onto a
// single read/write register bus, with completion tracking and a WAIT timeout.
module reg_bus_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_dn,
  output logic [NREQ-1:0]          rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_rd_q,
  output logic                     mem_wr_q,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rd_dn,
  input  logic                     mem_wr_dn,
  output logic                     bus_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   last_owner;
  logic            op_wr;
  logic [7:0]      wait_cnt;

  logic [NREQ-1:0] pending;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   winner;
  logic            found;

  // Search starts just after the previous owner and wraps, so every requester
  // is reached within NREQ grants.
  always_comb begin
    pending = req_rd | req_wr;
    rr_idx  = '0;
    winner  = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = IW'((32'(last_owner) + k) % NREQ);
      if (!found && pending[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  assign bus_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= IW'(NREQ - 1);
      op_wr      <= 1'b0;
      wait_cnt   <= '0;
      gnt        <= '0;
      rsp_dn     <= '0;
      rsp_err    <= '0;
      rsp_rdata  <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      rsp_dn   <= '0;
      rsp_err  <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            last_owner <= winner;
            op_wr      <= req_wr[winner];
            gnt        <= NREQ'(1) << winner;
            mem_rd_q   <= !req_wr[winner];
            mem_wr_q   <= req_wr[winner];
            mem_addr   <= req_addr[winner*ADDR_W +: ADDR_W];
            mem_wdata  <= req_wdata[winner*DATA_W +: DATA_W];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Completion is checked before the timeout so a last-cycle dn wins.
          if (op_wr ? mem_wr_dn : mem_rd_dn) begin
            if (!op_wr) rsp_rdata <= mem_rdata;
            rsp_dn <= gnt;
            gnt    <= '0;
            state  <= DONE;
          end else if (wait_cnt == 8'(TMO - 1)) begin
            rsp_err   <= gnt;
            gnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          mem_addr  <= '0;
          mem_wdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed vector table, reset abort
// sequence, and randomized transactions against a round-robin reference model.
module tb_reg_bus_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_rd, req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, rsp_dn, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic              mem_rd_q, mem_wr_q;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_rd_dn, mem_wr_dn;
  logic              bus_busy;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_dn(rsp_dn), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_rd_q(mem_rd_q), .mem_wr_q(mem_wr_q), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd_dn(mem_rd_dn), .mem_wr_dn(mem_wr_dn),
    .bus_busy(bus_busy)
  );

  int checks = 0;
  int errors = 0;
  int model_last;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    int          dly;
    logic [31:0] base;
    logic [31:0] rdat;
    logic [3:0]  exp_gnt;
    logic        exp_wr;
    logic        exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Priority list rebuilt from scratch for every decision: requesters after
  // the previous owner first, the previous owner itself last.
  function automatic int model_pick(input logic [3:0] pend, input int last);
    int order[$];
    for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
    foreach (order[j]) if (pend[order[j]]) return order[j];
    return -1;
  endfunction

  // dly = WAIT cycle (1-based) in which the matching dn is given; 0 = never.
  task automatic run_txn(input logic [3:0] rd, input logic [3:0] wr, input int dly,
                         input logic [31:0] base, input logic [31:0] rdat,
                         input logic [3:0] exp_gnt, input logic exp_wr, input logic exp_err);
    int          oi;
    int          n;
    logic [31:0] exp_addr, exp_wdata;
    logic        seen;
    oi = 0;
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) oi = i;
    exp_addr  = base + (32'(oi) << 8);
    exp_wdata = ~base + 32'(oi);
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = base + (32'(i) << 8);
      req_wdata[i*DW +: DW] = ~base + 32'(i);
    end
    req_rd = rd;
    req_wr = wr;
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      step();
      seen = mem_rd_q | mem_wr_q;
    end
    if (!seen) begin
      chk("strobe_wait", 0, 1);
      req_rd = '0; req_wr = '0;
      repeat (TMO + 4) step();
      return;
    end
    chk("gnt", 64'(gnt), 64'(exp_gnt));
    chk("wr_q", 64'(mem_wr_q), 64'(exp_wr));
    chk("rd_q", 64'(mem_rd_q), 64'(!exp_wr));
    chk("addr", 64'(mem_addr), 64'(exp_addr));
    chk("wdata", 64'(mem_wdata), 64'(exp_wdata));
    chk("busy_issue", 64'(bus_busy), 1);
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    if (dly % 2 == 1) begin
      req_rd = '0; req_wr = '0;
    end
    // matching dn during ISSUE must be ignored
    mem_rd_dn = !exp_wr;
    mem_wr_dn = exp_wr;
    mem_rdata = ~rdat;
    step();
    mem_rd_dn = 1'b0;
    mem_wr_dn = 1'b0;
    chk("strobe_once", 64'({mem_rd_q, mem_wr_q}), 0);
    n = 0;
    for (int w = 1; w <= TMO + 3 && n == 0; w++) begin
      if (w == dly) begin
        mem_rd_dn = !exp_wr;
        mem_wr_dn = exp_wr;
        mem_rdata = rdat;
      end else begin
        mem_rd_dn = exp_wr;
        mem_wr_dn = !exp_wr;
        mem_rdata = ~rdat;
      end
      step();
      mem_rd_dn = 1'b0;
      mem_wr_dn = 1'b0;
      if ((rsp_dn | rsp_err) != 0) n = w;
      else chk("gnt_wait", 64'(gnt), 64'(exp_gnt));
    end
    if (n == 0) begin
      chk("rsp_wait", 0, 1);
    end else begin
      chk("latency", 64'(n), 64'(exp_err ? TMO : dly));
      chk("rsp_dn", 64'(rsp_dn), 64'(exp_err ? 4'b0 : exp_gnt));
      chk("rsp_err", 64'(rsp_err), 64'(exp_err ? exp_gnt : 4'b0));
      chk("gnt_rsp", 64'(gnt), 0);
      if (!exp_err) begin
        chk("addr_hold", 64'(mem_addr), 64'(exp_addr));
        chk("wdata_hold", 64'(mem_wdata), 64'(exp_wdata));
        if (!exp_wr) chk("rdata", 64'(rsp_rdata), 64'(rdat));
      end
    end
    req_rd = '0;
    req_wr = '0;
    step();
    chk("idle_busy", 64'(bus_busy), 0);
    chk("idle_addr", 64'({mem_addr, mem_wdata}), 0);
    chk("idle_rsp", 64'({rsp_dn, rsp_err, gnt}), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'h0, 4'hF, 2, 32'h0000_1000, 32'h0,         4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{4'h0, 4'hF, 1, 32'h0000_2000, 32'h0,         4'b0010, 1'b1, 1'b0};
    tbl[2]  = '{4'h0, 4'hF, 3, 32'h0000_3000, 32'h0,         4'b0100, 1'b1, 1'b0};
    tbl[3]  = '{4'h0, 4'hF, 2, 32'h0000_4000, 32'h0,         4'b1000, 1'b1, 1'b0};
    tbl[4]  = '{4'h0, 4'hF, 1, 32'h0000_5000, 32'h0,         4'b0001, 1'b1, 1'b0};
    tbl[5]  = '{4'h1, 4'h0, 3, 32'h0000_0005, 32'hDEADBEEF,  4'b0001, 1'b0, 1'b0};
    tbl[6]  = '{4'h4, 4'h4, 1, 32'h0000_6000, 32'h0,         4'b0100, 1'b1, 1'b0};
    tbl[7]  = '{4'h2, 4'h0, 0, 32'h0000_7000, 32'h1234_5678, 4'b0010, 1'b0, 1'b1};
    tbl[8]  = '{4'hA, 4'h0, 4, 32'h0000_8000, 32'hCAFE_F00D, 4'b1000, 1'b0, 1'b0};
    tbl[9]  = '{4'h0, 4'hE, 1, 32'h0000_9000, 32'h0,         4'b0010, 1'b1, 1'b0};
    tbl[10] = '{4'h5, 4'h0, 5, 32'h0000_A000, 32'h5555_AAAA, 4'b0100, 1'b0, 1'b1};
    tbl[11] = '{4'h3, 4'h8, 2, 32'h0000_B000, 32'h0,         4'b1000, 1'b1, 1'b0};

    rst = 1'b1;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_rd_dn = 1'b0; mem_wr_dn = 1'b0;
    repeat (3) step();
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_rsp", 64'({rsp_dn, rsp_err}), 0);
    chk("rst_strobe", 64'({mem_rd_q, mem_wr_q}), 0);
    chk("rst_addr", 64'({mem_addr, mem_wdata}), 0);
    chk("rst_rdata", 64'(rsp_rdata), 0);
    chk("rst_busy", 64'(bus_busy), 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 12; v++)
      run_txn(tbl[v].rd, tbl[v].wr, tbl[v].dly, tbl[v].base, tbl[v].rdat,
              tbl[v].exp_gnt, tbl[v].exp_wr, tbl[v].exp_err);

    // reset while waiting on the bus, then a late dn
    req_addr = '0; req_wdata = '0;
    req_rd = 4'b0010;
    step();
    chk("rw_strobe", 64'({mem_rd_q, gnt}), 64'({1'b1, 4'b0010}));
    step();
    chk("rw_wait", 64'({bus_busy, gnt}), 64'({1'b1, 4'b0010}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_rd = '0;
    chk("rw_rst_out", 64'({gnt, bus_busy, mem_rd_q, mem_wr_q}), 0);
    mem_rd_dn = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_rd_dn = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("rw_silent", 64'({rsp_dn, rsp_err, gnt, bus_busy}), 0);
      step();
    end
    run_txn(4'hF, 4'h0, 2, 32'h0000_C000, 32'h0BAD_CAFE, 4'b0001, 1'b0, 1'b0);
    model_last = 0;

    for (int r = 0; r < 120; r++) begin
      logic [3:0]  rd, wr, pend;
      logic [31:0] base, rdat;
      int          dly, win;
      logic        e_err;
      rd   = 4'($urandom_range(0, 15));
      wr   = 4'($urandom_range(0, 15));
      if ((rd | wr) == 4'b0) rd = 4'b1 << $urandom_range(0, 3);
      dly  = $urandom_range(0, 6);
      base = $urandom;
      rdat = $urandom;
      pend = rd | wr;
      win  = model_pick(pend, model_last);
      e_err = (dly == 0) || (dly > TMO);
      run_txn(rd, wr, dly, base, rdat, 4'b1 << win, wr[win], e_err);
      model_last = win;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Parameters
REQ-001 NREQ, 4, number of register-manager requesters (cond, src1, src0, dst).
REQ-002 ADDR_W, 32, bus address width.
REQ-003 DATA_W, 32, bus data width.
REQ-004 TMO, 255, WAIT-state timeout in cycles, range 1..255.

Interface
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_rd  in  NREQ  per-requester read request, level, held until rsp_dn/rsp_err.
REQ-008 req_wr  in  NREQ  per-requester write request, level, held until rsp_dn/rsp_err.
REQ-009 req_addr  in  NREQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  NREQ*DATA_W  per-requester write data, sliced as req_addr.
REQ-011 gnt  out  NREQ  one-hot owner of bus; all-zero when idle.
REQ-012 rsp_dn  out  NREQ  one-cycle completion pulse to owner.
REQ-013 rsp_err  out  NREQ  one-cycle timeout pulse to owner.
REQ-014 rsp_rdata  out  DATA_W  read data, valid only in the rsp_dn cycle of a read.
REQ-015 mem_rd_q / mem_wr_q  out  1  one-cycle bus read/write strobe.
REQ-016 mem_addr  out  ADDR_W  bus address, stable from strobe cycle to completion.
REQ-017 mem_wdata  out  DATA_W  bus write data, stable as mem_addr.
REQ-018 mem_rdata  in  DATA_W  bus read data, sampled when mem_rd_dn=1.
REQ-019 mem_rd_dn / mem_wr_dn  in  1  bus completion pulses.
REQ-020 bus_busy  out  1  high in every non-IDLE state.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, DONE; encoded in 2 bits.
REQ-022 IDLE: pending = req_rd|req_wr; if pending!=0, select winner, latch index, op, addr, wdata; go ISSUE next cycle.
REQ-023 Arbitration round-robin: search starts at (last_owner+1) mod NREQ, wraps; last_owner updates on every grant.
REQ-024 Requester asserting req_rd and req_wr together SHALL be treated as write.
REQ-025 ISSUE: gnt one-hot, exactly one of mem_rd_q/mem_wr_q high for this single cycle; go WAIT.
REQ-026 WAIT: gnt held, strobes low; completion = mem_rd_dn for read, mem_wr_dn for write; mismatched dn ignored.
REQ-027 On completion: latch mem_rdata (reads only), go DONE.
REQ-028 DONE: rsp_dn[owner]=1 one cycle, rsp_rdata valid; gnt deasserted; next state IDLE.
REQ-029 Request-to-strobe latency 1 cycle from IDLE sample; minimum transaction 4 cycles (IDLE, ISSUE, WAIT with dn, DONE).
REQ-030 Completion in the ISSUE cycle itself SHALL be ignored; only WAIT samples dn.
REQ-031 WAIT counter 8 bits, cleared on entering WAIT, increments per WAIT cycle; at count==TMO without completion: rsp_err[owner]=1 one cycle, go IDLE, no rsp_dn.
REQ-032 Completion in the same cycle counter reaches TMO SHALL win: rsp_dn path, no rsp_err.
REQ-033 Requester dropping its request mid-transaction SHALL not abort it; response still pulsed.
REQ-034 Latched addr/wdata SHALL not follow req_addr/req_wdata changes after IDLE sample.
REQ-035 mem_addr/mem_wdata SHALL be 0 when IDLE.

Reset
REQ-036 rst=1 at any edge: state IDLE, last_owner=NREQ-1, counter 0, latched addr/data/rdata 0, all outputs 0.
REQ-037 Reset mid-transaction aborts silently: no rsp_dn/rsp_err; late mem_*_dn after reset ignored.
REQ-038 First arbitration after reset starts search at requester 0.

Verification
REQ-039 Single read: req_rd=0001, addr0=0x5; mem_rd_dn 3 cycles after strobe with rdata 0xDEADBEEF -> mem_rd_q one cycle, mem_addr=0x5, rsp_dn=0001 with rsp_rdata=0xDEADBEEF.
REQ-040 All four req_wr held after reset -> grants in order 0001,0010,0100,1000,0001; each write strobes its own addr/wdata.
REQ-041 req_rd|req_wr both on requester 2 -> mem_wr_q asserted, mem_rd_q never; completion only on mem_wr_dn.
REQ-042 Read with no dn, TMO=4 -> rsp_err pulse after 4 WAIT cycles, no rsp_dn, FSM back to IDLE.
REQ-043 rst pulsed in WAIT, then mem_rd_dn -> no rsp_dn, gnt=0, bus_busy=0, next grant goes to requester 0.
REQ-044 mem_wr_dn during pending read, then mem_rd_dn -> only mem_rd_dn completes; single rsp_dn.
